// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types: FSM state and grant encodings.
// Optional fixed-priority build: MEM_ARB_FIXED_PRIO_EN.
package mem_arbiter_pkg;

  localparam int ARB_AW = 12;
  localparam int ARB_DW = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_F = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  localparam logic GNT_F = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr2.sv
// arb_rr2: 2-way picker (round-robin, or data-first when
// MEM_ARB_FIXED_PRIO_EN is defined).
module arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic f_elig,
  input  logic d_elig,
  input  logic last_grant,
  output logic gnt
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    gnt = GNT_F;
    if (d_elig) gnt = GNT_D;
  end
`else
  always_comb begin
    gnt = GNT_F;
    unique case ({f_elig, d_elig})
      2'b11:   gnt = ~last_grant;
      2'b01:   gnt = GNT_D;
      default: gnt = GNT_F;
    endcase
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported RAM between fetch and data.
// Optional fixed-priority tie-break: MEM_ARB_FIXED_PRIO_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = ARB_AW,
  parameter int DW = ARB_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_in,
  output logic          mem_load,
  input  logic [DW-1:0] mem_out
);

  state_e        state_q, state_d;
  logic          f_ack_q, f_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] f_rdata_q, f_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          last_grant;
  logic          gnt;
  logic          f_elig, d_elig;

  // A port is not re-granted while its own ack is still up.
  assign f_elig = f_req & ~f_ack_q;
  assign d_elig = d_req & ~d_ack_q;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign last_grant = GNT_D;
`else
  logic last_grant_q, last_grant_d;
  assign last_grant = last_grant_q;

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && (f_elig || d_elig))
      last_grant_d = gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= GNT_D;
    else        last_grant_q <= last_grant_d;
  end
`endif

  arb_rr2 u_pick (
    .f_elig     (f_elig),
    .d_elig     (d_elig),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  always_comb begin
    state_d   = state_q;
    f_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (f_elig || d_elig)
          state_d = (gnt == GNT_D) ? SERVE_D : SERVE_F;
      end
      SERVE_F: begin
        f_rdata_d = mem_out;
        f_ack_d   = 1'b1;
        state_d   = IDLE;
      end
      SERVE_D: begin
        d_rdata_d = mem_out;
        d_ack_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      f_ack_q   <= f_ack_d;
      d_ack_q   <= d_ack_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Decoded from state so reset kills a write immediately.
  assign mem_load    = (state_q == SERVE_D) & d_we;
  assign mem_address = (state_q == SERVE_D) ? d_addr : f_addr;
  assign mem_in      = d_wdata;

  assign f_ack   = f_ack_q;
  assign d_ack   = d_ack_q;
  assign f_rdata = f_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 4K x 16 RAM.
// Expects fixed priority when MEM_ARB_FIXED_PRIO_EN is defined.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        f_req;
  logic [11:0] f_addr;
  logic        f_ack;
  logic [15:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [11:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic [11:0] mem_address;
  logic [15:0] mem_in;
  logic        mem_load;
  logic [15:0] mem_out;

  logic [15:0] ram [4096];

  int vectors = 0;
  int errors  = 0;

  mem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .f_req       (f_req),
    .f_addr      (f_addr),
    .f_ack       (f_ack),
    .f_rdata     (f_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ack       (d_ack),
    .d_rdata     (d_rdata),
    .mem_address (mem_address),
    .mem_in      (mem_in),
    .mem_load    (mem_load),
    .mem_out     (mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_out = ram[mem_address];

  always @(posedge clk)
    if (mem_load) ram[mem_address] <= mem_in;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic exp_f, exp_d, first_d;
    for (int i = 0; i < 4096; i++) ram[i] = 16'h0;
    ram[12'h123] = 16'hBEEF;
    ram[12'hFFF] = 16'h5555;
    ram[12'h0AA] = 16'h1111;
    rst_n = 1'b0; f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    tick();
    tick();
    chk("rst_f_ack", 32'(f_ack), 32'h0);
    chk("rst_d_ack", 32'(d_ack), 32'h0);
    chk("rst_f_rdata", 32'(f_rdata), 32'h0);
    chk("rst_d_rdata", 32'(d_rdata), 32'h0);
    chk("rst_load", 32'(mem_load), 32'h0);
    rst_n = 1'b1;
    tick();

    // fetch read
    f_req = 1'b1; f_addr = 12'h123;
    chk("f_n_ack", 32'(f_ack), 32'h0);
    tick();
    chk("f_n1_ack", 32'(f_ack), 32'h0);
    chk("f_n1_addr", 32'(mem_address), 32'h123);
    chk("f_n1_load", 32'(mem_load), 32'h0);
    tick();
    chk("f_n2_ack", 32'(f_ack), 32'h1);
    chk("f_n2_rdata", 32'(f_rdata), 32'hBEEF);
    chk("f_n2_load", 32'(mem_load), 32'h0);
    f_req = 1'b0;
    tick();
    chk("f_ack_pulse", 32'(f_ack), 32'h0);
    chk("f_rdata_hold", 32'(f_rdata), 32'hBEEF);

    // data write, read-before-write
    d_req = 1'b1; d_we = 1'b1;
    d_addr = 12'hFFF; d_wdata = 16'h1234;
    chk("w_idle_load", 32'(mem_load), 32'h0);
    tick();
    chk("w_serve_load", 32'(mem_load), 32'h1);
    chk("w_serve_addr", 32'(mem_address), 32'hFFF);
    chk("w_serve_in", 32'(mem_in), 32'h1234);
    tick();
    chk("w_ack", 32'(d_ack), 32'h1);
    chk("w_old_rdata", 32'(d_rdata), 32'h5555);
    chk("w_load_drop", 32'(mem_load), 32'h0);
    chk("w_ram", 32'(ram[12'hFFF]), 32'h1234);
    d_req = 1'b0;
    tick();
    chk("w_ack_pulse", 32'(d_ack), 32'h0);

    // data read back
    d_req = 1'b1; d_we = 1'b0;
    tick();
    chk("r_load", 32'(mem_load), 32'h0);
    tick();
    chk("r_ack", 32'(d_ack), 32'h1);
    chk("r_rdata", 32'(d_rdata), 32'h1234);
    d_req = 1'b0;
    tick();

    // contention: both held continuously
`ifdef MEM_ARB_FIXED_PRIO_EN
    first_d = 1'b1;
`else
    first_d = 1'b0;
`endif
    f_req = 1'b1; f_addr = 12'h123;
    d_req = 1'b1; d_we = 1'b0; d_addr = 12'hFFF;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_f = 1'b0;
      exp_d = 1'b0;
      if (k % 2 == 0) begin
        if (((k / 2) % 2 == 1) ^ first_d) exp_f = 1'b1;
        else exp_d = 1'b1;
      end
      chk($sformatf("rr_f_ack_c%0d", k), 32'(f_ack), 32'(exp_f));
      chk($sformatf("rr_d_ack_c%0d", k), 32'(d_ack), 32'(exp_d));
    end
    f_req = 1'b0; d_req = 1'b0;
    tick();
    tick();
    chk("rr_quiet_f", 32'(f_ack), 32'h0);
    chk("rr_quiet_d", 32'(d_ack), 32'h0);

    // reset during a SERVE_D write
    d_req = 1'b1; d_we = 1'b1;
    d_addr = 12'h0AA; d_wdata = 16'hDEAD;
    tick();
    chk("mr_load_pre", 32'(mem_load), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mr_load_drop", 32'(mem_load), 32'h0);
    chk("mr_addr", 32'(mem_address), 32'h123);
    chk("mr_f_rdata", 32'(f_rdata), 32'h0);
    chk("mr_d_rdata", 32'(d_rdata), 32'h0);
    chk("mr_d_ack", 32'(d_ack), 32'h0);
    tick();
    chk("mr_ram_kept", 32'(ram[12'h0AA]), 32'h1111);
    rst_n = 1'b1;
    tick();
    tick();
    chk("mr_resume_ack", 32'(d_ack), 32'h1);
    chk("mr_resume_rd", 32'(d_rdata), 32'h1111);
    chk("mr_resume_ram", 32'(ram[12'h0AA]), 32'hDEAD);
    d_req = 1'b0; d_we = 1'b0;
    tick();

    // req held one cycle into its ack
    f_req = 1'b1; f_addr = 12'h123;
    tick();
    tick();
    chk("hold_ack", 32'(f_ack), 32'h1);
    tick();
    f_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold_nodup_%0d", k), 32'(f_ack), 32'h0);
      tick();
    end
    f_req = 1'b1;
    tick();
    chk("fresh_wait", 32'(f_ack), 32'h0);
    tick();
    chk("fresh_ack", 32'(f_ack), 32'h1);
    f_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // never both acks together
  always @(negedge clk)
    if (rst_n && f_ack && d_ack) begin
      errors++;
      $error("FAIL both_acks observed=11 expected=not both");
    end

endmodule
